uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: rx

Interface
REQ-001 SHALL have parameter OSR, default 16, meaning tick samples per serial bit (even, >= 4).
REQ-002 SHALL have port tick, input, 1, the single clock, at the oversample rate; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-low (the block resets on a tick edge while rst = 0).
REQ-004 SHALL have port in, input, 1, asynchronous serial line; idles high.
REQ-005 SHALL have port csr, input, 32, control word with the same fields as the transmit side:
- csr[3:0] = data bits N (0 means 8; 1..15 legal);
- csr[4] = two stop bits;
- csr[5] = parity enable;
- csr[6] = odd parity (0 = even).
REQ-006 SHALL have port fifo_full, input, 1, receive FIFO cannot accept a write.
REQ-007 SHALL have port rx_data, output, 16, received word, LSB = first data bit, bits >= N zero.
REQ-008 SHALL have port rx_valid, output, 1, one-tick write strobe to the receive FIFO.
REQ-009 SHALL have ports parity_err, frame_err and overrun, each output, 1, status flags valid while rx_valid = 1.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL pass in through a 2-flop synchronizer with reset value 1; all decisions use the synchronized value s_in.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, with a sample counter scnt (log2 OSR bits) and a bit counter bcnt (4 bits).
REQ-013 IDLE: on s_in = 0 while the previous s_in = 1 (falling edge), go to START with scnt = 0; a low level without a preceding high is ignored.
REQ-014 START: at scnt = OSR/2-1 (mid-bit), if s_in = 1 it is a false start, so return to IDLE with no output; otherwise go to DATA with scnt = 0 and bcnt = 0.
REQ-015 DATA:
- at scnt = OSR-1, shift s_in into shift register bit bcnt and increment bcnt;
- after bit N-1 is sampled, go to PARITY if csr[5] = 1, else STOP1.
REQ-016 PARITY: at scnt = OSR-1, sample the bit; parity_err = (XOR of N data bits XOR sample) != csr[6].
REQ-017 STOP1:
- at scnt = OSR-1, sample; s_in = 0 sets frame_err;
- if csr[4] = 1 and no error so far, go to STOP2;
- otherwise complete the frame.
REQ-018 STOP2: at scnt = OSR-1, sample; s_in = 0 sets frame_err; complete the frame.
REQ-019 Frame completion:
- on the tick after the final stop sample, rx_valid = 1 for exactly one tick;
- rx_data holds the word, and flags are registered at the same time;
- FSM returns to IDLE.
REQ-020 rx_data and flags SHALL hold their values until the next completion; parity_err = 0 whenever csr[5] = 0.
REQ-021 Completion with fifo_full = 1:
- rx_valid SHALL stay 0 and the word is dropped;
- overrun = 1 with a one-tick pulse on the same tick;
- the FSM still returns to IDLE.
REQ-022 After a frame_err, IDLE SHALL not accept a new start until s_in has been 1 for at least one tick (break handling).
REQ-023 csr SHALL be sampled into a shadow register on entry to START; mid-frame csr changes affect only the next frame.
REQ-024 Latency from the start-bit falling edge on in to rx_valid SHALL be 2 + OSR/2 + OSR*(N + P + S) + 1 ticks ± 1, where P = parity bit, S = stop bits.

Reset
REQ-025 With rst = 0 at a tick edge:
- FSM = IDLE; scnt = bcnt = 0;
- synchronizer = 1, shift register = 0;
- rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_valid; reception resumes only on a new falling edge after rst = 1.

Verification
REQ-027 csr = 0x08 (8N1), OSR = 16, send 0xA5 -> one rx_valid pulse, rx_data = 0x00A5, all flags 0, at the latency given by REQ-024.
REQ-028 csr = 0x68 (8O1), send 0x3C with a correct odd parity bit (1) then with a wrong one -> parity_err 0 then 1; both words delivered as 0x003C.
REQ-029 csr = 0x18 (8N2), second stop bit driven low -> rx_valid with frame_err = 1; a new start while the line is still low is ignored until the line goes high.
REQ-030 Low glitch of 4 ticks on idle line -> false start, no rx_valid, busy returns to 0 within OSR/2 + 3 ticks.
REQ-031 fifo_full = 1 at completion of 0x55 -> rx_valid = 0, overrun pulse of 1 tick; the next frame 0x12 with fifo_full = 0 -> rx_data = 0x0012.
REQ-032 rst = 0 during DATA bit 3, then a clean frame 0x81 -> no output from the aborted frame; rx_data = 0x0081 from the clean frame.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop detection with a 2-flop
// input synchronizer, per-frame shadowed configuration and status flags.
module uart_rx #(
  parameter int OSR = 16
) (
  input  logic        tick,
  input  logic        rst,
  input  logic        in,
  input  logic [31:0] csr,
  input  logic        fifo_full,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);
  localparam int SW = $clog2(OSR);
  localparam logic [SW-1:0] MID  = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OSR - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t        state;
  logic [SW-1:0] scnt;
  logic [3:0]    bcnt;
  logic [1:0]    sync;
  logic          s_in;
  logic          s_prev;
  logic          brk;
  logic [15:0]   shreg;
  logic [3:0]    cfg_n;
  logic          cfg_two;
  logic          cfg_par;
  logic          cfg_odd;
  logic          par_err_p;
  logic [3:0]    last_bit;
  logic          stop_done;
  logic          unused_csr;

  assign s_in       = sync[1];
  assign last_bit   = (cfg_n == 4'd0) ? 4'd7 : cfg_n - 4'd1;
  assign unused_csr = ^csr[31:7];
  assign stop_done  = (scnt == LAST) &&
                      ((state == STOP2) ||
                       (state == STOP1 && !(s_in && cfg_two && !par_err_p)));

  always_ff @(posedge tick) begin
    if (!rst) begin
      state      <= IDLE;
      scnt       <= '0;
      bcnt       <= '0;
      sync       <= 2'b11;
      s_prev     <= 1'b0;
      // Start out as if after a break so a line still low from an aborted
      // frame must return high (through the whole sync pipe) before a start.
      brk        <= 1'b1;
      shreg      <= '0;
      cfg_n      <= '0;
      cfg_two    <= 1'b0;
      cfg_par    <= 1'b0;
      cfg_odd    <= 1'b0;
      par_err_p  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync     <= {sync[0], in};
      s_prev   <= s_in;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (s_prev && s_in && sync[0]) brk <= 1'b0;
          if (!brk && s_prev && !s_in) begin
            state   <= START;
            scnt    <= '0;
            busy    <= 1'b1;
            cfg_n   <= csr[3:0];
            cfg_two <= csr[4];
            cfg_par <= csr[5];
            cfg_odd <= csr[6];
          end
        end
        START: begin
          if (scnt == MID) begin
            if (s_in) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= DATA;
              scnt      <= '0;
              bcnt      <= '0;
              shreg     <= '0;
              par_err_p <= 1'b0;
            end
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        DATA: begin
          if (scnt == LAST) begin
            scnt        <= '0;
            shreg[bcnt] <= s_in;
            bcnt        <= bcnt + 4'd1;
            if (bcnt == last_bit) state <= cfg_par ? PARITY : STOP1;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        PARITY: begin
          if (scnt == LAST) begin
            scnt      <= '0;
            par_err_p <= ((^shreg) ^ s_in) != cfg_odd;
            state     <= STOP1;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        STOP1: begin
          if (scnt == LAST) begin
            scnt <= '0;
            if (s_in && cfg_two && !par_err_p) state <= STOP2;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        STOP2: begin
          if (scnt == LAST) scnt <= '0;
          else              scnt <= scnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Frame completion; a full FIFO drops the word and pulses overrun instead.
      if (stop_done) begin
        state <= IDLE;
        busy  <= 1'b0;
        brk   <= !s_in;
        if (fifo_full) begin
          overrun <= 1'b1;
        end else begin
          rx_valid   <= 1'b1;
          rx_data    <= shreg;
          parity_err <= par_err_p;
          frame_err  <= !s_in;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed protocol cases plus randomized
// frames checked against a frame-level model (masked word, parity, latency).
module tb_uart_rx;
  localparam int OSR = 16;

  logic        tick;
  logic        rst;
  logic        line;
  logic [31:0] csr;
  logic        fifo_full;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  uart_rx #(.OSR(OSR)) dut (
    .tick      (tick),
    .rst       (rst),
    .in        (line),
    .csr       (csr),
    .fifo_full (fifo_full),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    tick = 1'b0;
    forever #5 tick = ~tick;
  end

  typedef struct {
    logic [15:0] data;
    logic        pe;
    logic        fe;
    int          cyc;
  } rec_t;

  rec_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int ovr_pulses = 0, ovr_run = 0, ovr_max = 0;
  int vld_run = 0, vld_max = 0;

  always @(posedge tick) cyc <= cyc + 1;

  // Monitor: record every delivered word and overrun/valid pulse widths.
  always @(negedge tick) begin
    rec_t r;
    if (rx_valid) begin
      r.data = rx_data;
      r.pe   = parity_err;
      r.fe   = frame_err;
      r.cyc  = cyc;
      q.push_back(r);
      vld_run++;
    end else begin
      vld_run = 0;
    end
    if (vld_run > vld_max) vld_max = vld_run;
    if (overrun) begin
      if (ovr_run == 0) ovr_pulses++;
      ovr_run++;
    end else begin
      ovr_run = 0;
    end
    if (ovr_run > ovr_max) ovr_max = ovr_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nmask(input int n);
    return 16'((32'd1 << n) - 1);
  endfunction

  function automatic int exp_latency(input int n, input int p, input int s);
    return 2 + OSR / 2 + OSR * (n + p + s) + 1;
  endfunction

  // Drive one serial frame; each bit lasts OSR ticks.
  task automatic send(input logic [15:0] data, input int n, input bit pen, input bit podd,
                      input bit pflip, input int nstop, input bit lastlow,
                      input bit scramble, output int t0);
    logic [15:0] m;
    m = data & nmask(n);
    @(negedge tick);
    t0 = cyc;
    line = 1'b0;
    repeat (OSR) @(negedge tick);
    if (scramble) csr = $urandom();
    for (int i = 0; i < n; i++) begin
      line = data[i];
      repeat (OSR) @(negedge tick);
    end
    if (pen) begin
      line = (^m) ^ podd ^ pflip;
      repeat (OSR) @(negedge tick);
    end
    for (int s = 0; s < nstop; s++) begin
      line = !(lastlow && s == nstop - 1);
      repeat (OSR) @(negedge tick);
    end
    if (!lastlow) line = 1'b1;
    repeat (4) @(negedge tick);
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] exp_data, input bit exp_pe,
                              input bit exp_fe, input int t0, input int exp_lat);
    rec_t r;
    int lat;
    r.data = 16'h0;
    r.pe   = 1'b0;
    r.fe   = 1'b0;
    r.cyc  = 0;
    check({tag, " count"}, q.size(), 1);
    if (q.size() > 0) r = q.pop_front();
    q.delete();
    lat = r.cyc - t0;
    $display("rx %s: data=%04h pe=%0b fe=%0b latency=%0d", tag, r.data, r.pe, r.fe, lat);
    check({tag, " data"}, r.data, exp_data);
    check({tag, " parity_err"}, r.pe, exp_pe);
    check({tag, " frame_err"}, r.fe, exp_fe);
    checks++;
    assert (lat >= exp_lat - 1 && lat <= exp_lat + 1) else begin
      errors++;
      $error("FAIL %s latency: got %0d expected %0d +-1", tag, lat, exp_lat);
    end
  endtask

  initial begin
    int t0;
    int busy_hi;
    int settle;
    int ovr_before;
    logic [15:0] d;
    logic [3:0] nenc;
    int n;
    bit pen, podd, two;

    rst = 1'b0;
    line = 1'b1;
    csr = 32'h08;
    fifo_full = 1'b0;
    repeat (4) @(negedge tick);
    check("reset rx_data", rx_data, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset flags", {parity_err, frame_err, overrun}, 0);
    check("reset busy", busy, 0);
    rst = 1'b1;
    repeat (OSR) @(negedge tick);

    // 8N1 0xA5
    csr = 32'h08;
    send(16'hA5, 8, 0, 0, 0, 1, 0, 0, t0);
    expect_frame("8N1 A5", 16'h00A5, 0, 0, t0, exp_latency(8, 0, 1));

    // 8O1 with correct then wrong parity
    csr = 32'h68;
    send(16'h3C, 8, 1, 1, 0, 1, 0, 0, t0);
    expect_frame("8O1 good", 16'h003C, 0, 0, t0, exp_latency(8, 1, 1));
    send(16'h3C, 8, 1, 1, 1, 1, 0, 0, t0);
    expect_frame("8O1 bad", 16'h003C, 1, 0, t0, exp_latency(8, 1, 1));

    // 8N2 with second stop low, line held low afterwards
    csr = 32'h18;
    send(16'hC3, 8, 0, 0, 0, 2, 1, 0, t0);
    expect_frame("8N2 ferr", 16'h00C3, 0, 1, t0, exp_latency(8, 0, 2));
    busy_hi = 0;
    for (int k = 0; k < 3 * OSR; k++) begin
      @(negedge tick);
      if (busy) busy_hi++;
    end
    check("break busy", busy_hi, 0);
    check("break no word", q.size(), 0);
    line = 1'b1;
    repeat (OSR) @(negedge tick);
    send(16'h5A, 8, 0, 0, 0, 2, 0, 0, t0);
    expect_frame("8N2 after break", 16'h005A, 0, 0, t0, exp_latency(8, 0, 2));

    // 4-tick low glitch: false start
    csr = 32'h08;
    busy_hi = 0;
    settle = 0;
    @(negedge tick);
    line = 1'b0;
    for (int k = 1; k <= 3 * OSR; k++) begin
      @(negedge tick);
      if (k == 4) line = 1'b1;
      if (busy) busy_hi++;
      if (settle == 0 && busy_hi > 0 && !busy) settle = k;
    end
    $display("glitch: busy ticks=%0d settled at %0d", busy_hi, settle);
    check("glitch busy seen", busy_hi > 0, 1);
    check("glitch settle", settle >= 1 && settle <= OSR / 2 + 3, 1);
    check("glitch no word", q.size(), 0);

    // Overrun on full FIFO, then a normal frame
    ovr_before = ovr_pulses;
    fifo_full = 1'b1;
    send(16'h55, 8, 0, 0, 0, 1, 0, 0, t0);
    $display("overrun frame: pulses=%0d words=%0d", ovr_pulses - ovr_before, q.size());
    check("overrun no word", q.size(), 0);
    check("overrun pulses", ovr_pulses - ovr_before, 1);
    check("overrun width", ovr_max, 1);
    check("overrun busy", busy, 0);
    fifo_full = 1'b0;
    send(16'h12, 8, 0, 0, 0, 1, 0, 0, t0);
    expect_frame("after overrun", 16'h0012, 0, 0, t0, exp_latency(8, 0, 1));

    // Reset during data bit 3, then a clean frame
    @(negedge tick);
    line = 1'b0;
    repeat (OSR) @(negedge tick);
    line = 1'b1;
    repeat (OSR) @(negedge tick);
    line = 1'b0;
    repeat (OSR) @(negedge tick);
    line = 1'b1;
    repeat (OSR) @(negedge tick);
    line = 1'b0;
    repeat (OSR / 2) @(negedge tick);
    rst = 1'b0;
    repeat (2) @(negedge tick);
    check("midreset busy", busy, 0);
    check("midreset rx_data", rx_data, 0);
    rst = 1'b1;
    line = 1'b1;
    repeat (3 * OSR) @(negedge tick);
    check("midreset no word", q.size(), 0);
    send(16'h81, 8, 0, 0, 0, 1, 0, 0, t0);
    expect_frame("after reset", 16'h0081, 0, 0, t0, exp_latency(8, 0, 1));

    // Randomized clean frames; csr is scrambled mid-frame to exercise the shadow.
    for (int f = 0; f < 10; f++) begin
      nenc = 4'($urandom_range(0, 15));
      n    = (nenc == 4'd0) ? 8 : int'(nenc);
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      two  = 1'($urandom_range(0, 1));
      d    = 16'($urandom_range(0, 65535));
      csr  = $urandom();
      csr[3:0] = nenc;
      csr[4] = two;
      csr[5] = pen;
      csr[6] = podd;
      send(d, n, pen, podd, 0, two ? 2 : 1, 0, 1, t0);
      expect_frame($sformatf("rand%0d n=%0d p=%0b o=%0b s=%0d", f, n, pen, podd, two ? 2 : 1),
                   d & nmask(n), 0, 0, t0, exp_latency(n, pen ? 1 : 0, two ? 2 : 1));
    end

    check("rx_valid width", vld_max, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
